// File: rtl/local_flit_injector_pkg.sv
// Shared NoC definitions seen by the local flit injector: flit geometry and port index.
// Also a small helper for request length validation.
package local_flit_injector_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = TAM_FLIT / 2;
    localparam int LOCAL      = 4;

    function automatic logic len_in_range(input logic [TAM_FLIT-1:0] len, input int max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/local_flit_injector.sv
// Packet source for a router local port: serialises header, size and payload flits
// under credit flow control.
module local_flit_injector
    import local_flit_injector_pkg::*;
#(
    parameter logic [TAM_FLIT-1:0] ADDRESS = '0,
    parameter int                  MAX_LEN = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TAM_FLIT-1:0] req_target,
    input  logic [TAM_FLIT-1:0] req_len,
    input  logic [TAM_FLIT-1:0] req_seed,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                busy,
    output logic                pkt_sent,
    output logic                len_err,
    output logic [15:0]         sent_count
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t              state, state_nxt;
    logic [TAM_FLIT-1:0] len_q, seed_q;
    logic [TAM_FLIT-1:0] len_nxt, seed_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic                tx_nxt, pkt_nxt, err_nxt;
    logic [TAM_FLIT-1:0] data_nxt;
    logic [15:0]         cnt_nxt;
    logic                xfer, last;

    assign xfer      = tx & credit_i;
    assign last      = (TAM_FLIT'(idx_q) == len_q - 1'b1);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            seed_q     <= '0;
            idx_q      <= '0;
            tx         <= 1'b0;
            data_out   <= '0;
            pkt_sent   <= 1'b0;
            len_err    <= 1'b0;
            sent_count <= '0;
        end else begin
            state      <= state_nxt;
            len_q      <= len_nxt;
            seed_q     <= seed_nxt;
            idx_q      <= idx_nxt;
            tx         <= tx_nxt;
            data_out   <= data_nxt;
            pkt_sent   <= pkt_nxt;
            len_err    <= err_nxt;
            sent_count <= cnt_nxt;
        end
    end

    // Outputs are registered: each branch precomputes the flit shown next cycle.
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        seed_nxt  = seed_q;
        idx_nxt   = idx_q;
        tx_nxt    = tx;
        data_nxt  = data_out;
        pkt_nxt   = 1'b0;
        err_nxt   = 1'b0;
        cnt_nxt   = sent_count;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (len_in_range(req_len, MAX_LEN)) begin
                        len_nxt   = req_len;
                        seed_nxt  = req_seed;
                        tx_nxt    = 1'b1;
                        data_nxt  = req_target;
                        state_nxt = HEADER;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (xfer) begin
                    data_nxt  = len_q;
                    state_nxt = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    idx_nxt   = '0;
                    data_nxt  = ADDRESS;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (last) begin
                        tx_nxt    = 1'b0;
                        pkt_nxt   = 1'b1;
                        cnt_nxt   = sent_count + 16'd1;
                        state_nxt = IDLE;
                    end else begin
                        // flit k+1 carries seed + k
                        idx_nxt  = idx_q + 1'b1;
                        data_nxt = seed_q + TAM_FLIT'(idx_q);
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
